tt_um_serial_acc: RTL and testbench
===================================

TT_UM_SERIAL_ACC -- requirements
Module: tt_um_serial_acc

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8, giving the accumulator and operand width; legal values are 2..8.
REQ-002 The block SHALL have a parameter PAR, default 1, giving the bits processed per cycle; legal values are 1, 2 and 4, and PAR SHALL divide WIDTH.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port ena, input, 1 bit: always 1 when powered; ignored.
REQ-006 Port ui_in, input, 8 bits: operand B; bits [WIDTH-1:0] are used and the rest are ignored.
REQ-007 Port uio_in, input, 8 bits, used as follows:
- [0] start.
- [1] sub (1 = subtract).
- [2] clear.
- [7:3] ignored.
REQ-008 Port uo_out, output, 8 bits: ACC[WIDTH-1:0], zero-extended to 8 bits.
REQ-009 Port uio_out, output, 8 bits, driven as follows:
- [3:0] = 0.
- [4] busy.
- [5] done.
- [6] carry flag.
- [7] overflow flag.
REQ-010 Port uio_oe, output, 8 bits: SHALL be constant 8'hF0.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 IDLE with start=1 SHALL have this effect in one cycle:
- Capture B (ui_in) and the sub bit.
- Set carry-in to the captured sub value.
- Clear the beat counter.
- Go to RUN.
REQ-013 IDLE with start=0 and clear=1 SHALL set ACC, carry flag and overflow flag to 0 and stay in IDLE.
REQ-014 IDLE with start=1 and clear=1 SHALL use 0 as the ACC operand for the operation, so the result is 0 ± B.
REQ-015 Each RUN cycle SHALL add PAR bits, LSB first, using a ripple full-adder chain:
- Operand bits: ACC bits and B bits, with B inverted when sub=1.
- Carry: from the previous beat.
- ACC SHALL rotate right by PAR with the sum bits entering at the top, and B SHALL shift right by PAR.
REQ-016 RUN SHALL last exactly WIDTH/PAR cycles and then go to DONE, leaving ACC holding (ACC ± B) mod 2^WIDTH.
REQ-017 The flags SHALL be captured on the final RUN beat:
- carry flag = carry out of the MSB; for sub, 1 means no borrow.
- overflow flag = carry into the MSB XOR carry out of the MSB, i.e. two's-complement overflow.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-019 busy SHALL be 1 exactly while the state is RUN.
REQ-020 done SHALL be 1 exactly while the state is DONE.
REQ-021 While in RUN, uo_out SHALL show the partially rotated ACC; it is valid only when the state is IDLE or DONE.
REQ-022 start and clear SHALL be ignored in RUN and in DONE; they are not queued.
REQ-023 The captured sub and B values SHALL NOT change during RUN, whatever ui_in and uio_in do.
REQ-024 Latency SHALL be WIDTH/PAR+1 cycles from the start edge to done=1; throughput is one operation per WIDTH/PAR+2 cycles.
REQ-025 Results SHALL wrap modulo 2^WIDTH, with no saturation.
REQ-026 When WIDTH < 8, uo_out[7:WIDTH] SHALL be 0.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force all of the following, taking priority over every other input:
- State IDLE.
- ACC = 0, B register = 0, carry-in = 0, beat counter = 0.
- Carry flag = 0, overflow flag = 0.
REQ-028 While in reset, and in the first cycle after reset, the outputs SHALL be:
- uo_out = 0.
- uio_out = 0.
- uio_oe = 8'hF0.
REQ-029 Reset asserted during RUN or DONE SHALL abort the operation; no done pulse is produced and ACC = 0.

Verification (WIDTH=8, PAR=1 unless stated)
REQ-030 The bench SHALL cover these directed scenarios:
- Basic add: reset, then clear, then start add with B=0x05 → busy for 8 cycles, done on the 9th cycle after start, uo_out=0x05, carry=0, ovf=0.
- Unsigned wrap: ACC=0xFF, add B=0x01 → uo_out=0x00, carry=1, ovf=0.
- Signed overflow: ACC=0x7F, add B=0x01 → uo_out=0x80, carry=0, ovf=1.
- Subtract with borrow: ACC=0x03, sub B=0x05 → uo_out=0xFE, carry=0; then ACC=0x05, sub B=0x05 → uo_out=0x00, carry=1.
- Input isolation: start pulsed and ui_in changed during RUN → no restart, result uses the captured B, exactly one done pulse.
- Reset and parameters: rst_n=0 on RUN beat 3 → ACC=0, busy=0, no done. Also, with WIDTH=8, PAR=4, ACC=0x0F, add B=0xF1 → done 3 cycles after start, uo_out=0x00, carry=1.

Source files
------------

// File: rtl/tt_um_serial_acc.sv
// Bit-serial accumulator: ACC <= ACC +/- B, PAR bits per clock, LSB first.
// A start in IDLE captures B and the add/subtract mode, RUN ripples the
// operand through a PAR-bit full-adder slice for WIDTH/PAR beats, and DONE
// pulses for one cycle with the carry and overflow flags of the operation.
module tt_um_serial_acc #(
    parameter int WIDTH = 8,
    parameter int PAR   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int BEATS  = WIDTH / PAR;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic               sub_reg, sub_next;
    logic               cin_reg, cin_next;
    logic [BEAT_W-1:0]  beat_reg, beat_next;
    logic               carry_flag_reg, carry_flag_next;
    logic               ovf_flag_reg, ovf_flag_next;

    logic start, sub_in, clear;
    assign start  = uio_in[0];
    assign sub_in = uio_in[1];
    assign clear  = uio_in[2];

    // ena and the unused input bits are deliberately ignored
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, ui_in, uio_in[7:3], 1'b0};

    // Operand slice: B bits inverted for subtraction (carry-in supplies the +1)
    logic [PAR-1:0] b_eff;
    for (genvar gi = 0; gi < PAR; gi++) begin : g_b_eff
        assign b_eff[gi] = b_reg[gi] ^ sub_reg;
    end

    // Ripple full-adder chain over the low PAR bits of ACC and B
    logic [PAR:0]   carry_vec;
    logic [PAR-1:0] sum_bits;
    always_comb begin
        carry_vec    = '0;
        sum_bits     = '0;
        carry_vec[0] = cin_reg;
        for (int i = 0; i < PAR; i++) begin
            sum_bits[i]    = acc_reg[i] ^ b_eff[i] ^ carry_vec[i];
            carry_vec[i+1] = (acc_reg[i] & b_eff[i]) |
                             (carry_vec[i] & (acc_reg[i] ^ b_eff[i]));
        end
    end

    // ACC rotates right by PAR with the fresh sum bits entering at the top
    logic [WIDTH-1:0] sum_ext;
    logic [WIDTH-1:0] acc_rot;
    assign sum_ext = WIDTH'(sum_bits);
    assign acc_rot = (acc_reg >> PAR) | (sum_ext << (WIDTH - PAR));

    // Next-state and datapath update for IDLE / RUN / DONE
    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        b_next          = b_reg;
        sub_next        = sub_reg;
        cin_next        = cin_reg;
        beat_next       = beat_reg;
        carry_flag_next = carry_flag_reg;
        ovf_flag_next   = ovf_flag_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    b_next     = ui_in[WIDTH-1:0];
                    sub_next   = sub_in;
                    cin_next   = sub_in;
                    beat_next  = '0;
                    state_next = RUN;
                    if (clear) begin
                        acc_next = '0;
                    end
                end else if (clear) begin
                    acc_next        = '0;
                    carry_flag_next = 1'b0;
                    ovf_flag_next   = 1'b0;
                end
            end
            RUN: begin
                acc_next  = acc_rot;
                b_next    = b_reg >> PAR;
                cin_next  = carry_vec[PAR];
                beat_next = beat_reg + BEAT_W'(1);
                if (beat_reg == LAST_BEAT) begin
                    // The top bit of the slice is the MSB on the final beat
                    carry_flag_next = carry_vec[PAR];
                    ovf_flag_next   = carry_vec[PAR] ^ carry_vec[PAR-1];
                    state_next      = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset taking priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            b_reg          <= '0;
            sub_reg        <= 1'b0;
            cin_reg        <= 1'b0;
            beat_reg       <= '0;
            carry_flag_reg <= 1'b0;
            ovf_flag_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            b_reg          <= b_next;
            sub_reg        <= sub_next;
            cin_reg        <= cin_next;
            beat_reg       <= beat_next;
            carry_flag_reg <= carry_flag_next;
            ovf_flag_reg   <= ovf_flag_next;
        end
    end

    assign uo_out  = 8'(acc_reg);
    assign uio_out = {ovf_flag_reg, carry_flag_reg,
                      (state_reg == DONE), (state_reg == RUN), 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_serial_acc.sv
// Scoreboard bench for tt_um_serial_acc: one instance with PAR=1 and one with
// PAR=4 (both WIDTH=8). Stimulus pushes expected results computed with plain
// integer arithmetic; per-instance monitors pop and compare on each done pulse.
module tb_tt_um_serial_acc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena = 1'b1;
    logic [7:0] ui_in0, uio_in0, uo_out0, uio_out0, uio_oe0;
    logic [7:0] ui_in4, uio_in4, uo_out4, uio_out4, uio_oe4;

    always #5 clk = ~clk;

    tt_um_serial_acc #(.WIDTH(8), .PAR(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .ui_in(ui_in0), .uio_in(uio_in0),
        .uo_out(uo_out0), .uio_out(uio_out0), .uio_oe(uio_oe0)
    );

    tt_um_serial_acc #(.WIDTH(8), .PAR(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .ui_in(ui_in4), .uio_in(uio_in4),
        .uo_out(uo_out4), .uio_out(uio_out4), .uio_oe(uio_oe4)
    );

    typedef struct {
        int acc;
        int carry;
        int ovf;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q4[$];
    int   model_acc[2];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int which, input int b, input int u);
        if (which == 0) begin
            ui_in0  = 8'(b);
            uio_in0 = 8'(u);
        end else begin
            ui_in4  = 8'(b);
            uio_in4 = 8'(u);
        end
    endtask

    // Reference: ACC +/- B on 8-bit values, flags from full-width arithmetic
    task automatic op(input int which, input int b, input int sub, input int clr, input int noise);
        int   a, full, sa, sb, sr, beats;
        exp_t e;
        beats  = (which == 0) ? 8 : 2;
        a      = clr ? 0 : model_acc[which];
        full   = sub ? a + (255 - b) + 1 : a + b;
        sa     = (a >= 128) ? a - 256 : a;
        sb     = (b >= 128) ? b - 256 : b;
        sr     = sub ? sa - sb : sa + sb;
        e.acc   = full & 255;
        e.carry = (full >> 8) & 1;
        e.ovf   = (sr > 127 || sr < -128) ? 1 : 0;
        e.cyc   = cyc + beats + 1;
        model_acc[which] = e.acc;
        if (which == 0) q0.push_back(e);
        else q4.push_back(e);
        $display("op par%0d: %02h %s %02h (clr=%0d noise=%0d) -> acc=%02h c=%0d v=%0d",
                 (which == 0) ? 1 : 4, a, sub ? "-" : "+", b, clr, noise,
                 e.acc, e.carry, e.ovf);
        set_in(which, b, 1 | (sub << 1) | (clr << 2));
        step();
        for (int k = 0; k <= beats; k++) begin
            if (noise != 0) set_in(which, $urandom_range(0, 255), $urandom_range(0, 255));
            else set_in(which, 0, 0);
            step();
        end
        set_in(which, 0, 0);
    endtask

    task automatic do_clear(input int which);
        set_in(which, $urandom_range(0, 255), 4);
        step();
        set_in(which, 0, 0);
        model_acc[which] = 0;
        $display("clear par%0d", (which == 0) ? 1 : 4);
    endtask

    // Monitor for the PAR=1 instance
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && uio_out0[5] === 1'b1) begin
            if (q0.size() == 0) begin
                chk("unexpected_done_p1", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("acc_p1", int'(uo_out0), e.acc);
                chk("carry_p1", int'(uio_out0[6]), e.carry);
                chk("ovf_p1", int'(uio_out0[7]), e.ovf);
                chk("done_cycle_p1", cyc, e.cyc);
                chk("busy_at_done_p1", int'(uio_out0[4]), 0);
            end
        end
    end

    // Monitor for the PAR=4 instance
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && uio_out4[5] === 1'b1) begin
            if (q4.size() == 0) begin
                chk("unexpected_done_p4", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("acc_p4", int'(uo_out4), e.acc);
                chk("carry_p4", int'(uio_out4[6]), e.carry);
                chk("ovf_p4", int'(uio_out4[7]), e.ovf);
                chk("done_cycle_p4", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0);
        set_in(1, 0, 0);
        model_acc[0] = 0;
        model_acc[1] = 0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_uo_out", int'(uo_out0), 0);
        chk("rst_uio_out", int'(uio_out0), 0);
        chk("rst_uio_oe", int'(uio_oe0), 8'hF0);
        chk("rst_uo_out_p4", int'(uo_out4), 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_uo_out", int'(uo_out0), 0);
        chk("post_rst_uio_out", int'(uio_out0), 0);
        chk("post_rst_uio_oe", int'(uio_oe0), 8'hF0);
        step();

        // Directed scenarios on PAR=1
        do_clear(0);
        op(0, 8'h05, 0, 0, 0);
        op(0, 8'hFF, 0, 1, 0);
        op(0, 8'h01, 0, 0, 0);
        op(0, 8'h7F, 0, 1, 0);
        op(0, 8'h01, 0, 0, 0);
        op(0, 8'h03, 0, 1, 0);
        op(0, 8'h05, 1, 0, 0);
        op(0, 8'h05, 0, 1, 0);
        op(0, 8'h05, 1, 0, 0);
        // Input isolation: random start/clear/sub/ui_in throughout RUN and DONE
        op(0, 8'h22, 0, 0, 1);
        op(0, 8'h9C, 1, 0, 1);

        // Reset on the third RUN beat aborts the operation
        set_in(0, 8'h5A, 1);
        step();
        set_in(0, 0, 0);
        step();
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("abort_uo_out", int'(uo_out0), 0);
        chk("abort_busy", int'(uio_out0[4]), 0);
        chk("abort_uio_out", int'(uio_out0), 0);
        step();
        rst_n = 1'b1;
        model_acc[0] = 0;
        model_acc[1] = 0;
        $display("abort par1 on RUN beat 3");
        repeat (12) step();
        @(negedge clk);
        chk("abort_acc_stays_0", int'(uo_out0), 0);
        step();

        // Randomized operations on PAR=1
        for (int n = 0; n < 30; n++) begin
            op(0, $urandom_range(0, 255), $urandom_range(0, 1),
               ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 1));
        end

        // PAR=4 instance: directed then random
        do_clear(1);
        op(1, 8'h0F, 0, 1, 0);
        op(1, 8'hF1, 0, 0, 0);
        op(1, 8'h7F, 0, 1, 0);
        op(1, 8'h01, 0, 0, 1);
        for (int n = 0; n < 20; n++) begin
            op(1, $urandom_range(0, 255), $urandom_range(0, 1),
               ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 1));
        end

        repeat (4) step();
        @(negedge clk);
        chk("pending_p1", q0.size(), 0);
        chk("pending_p4", q4.size(), 0);
        chk("final_acc_p1", int'(uo_out0), model_acc[0]);
        chk("final_acc_p4", int'(uo_out4), model_acc[1]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
